pipe_hazard_ctrl: RTL

Pipeline sequencing controller for the 5-stage RV32 core. It drives the PC/IF-ID enables, the IF-ID flush and the ID-EXE bubble, and selects operand forwarding for EXE.
- Resolves load-use hazards.
- Sequences multicycle (MUL/DIV) ops through a start/done handshake with a timeout watchdog.
- Squashes wrong-path fetch on ID-resolved redirects (branch/jal).

---
 rtl/core_pkg.sv | 16 +
 rtl/fwd_sel.sv | 25 ++
 rtl/pipe_hazard_ctrl.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared types and constants for the pipeline sequencing controller.
package core_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MC_WAIT  = 2'd1,
    MC_DRAIN = 2'd2
  } state_t;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_EXE = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/fwd_sel.sv
// Per-operand EXE operand forwarding select; EXE beats MEM, x0 never forwards.
module fwd_sel
  import core_pkg::*;
(
  input  logic [4:0] rs,
  input  logic       use_rs,
  input  logic       exe_wreg,
  input  logic       exe_mem2reg,
  input  logic [4:0] exe_rd,
  input  logic       mem_wreg,
  input  logic [4:0] mem_rd,
  output logic [1:0] fwd
);

  always_comb begin
    fwd = FWD_REG;
    // A load in EXE has no result yet; its data is picked up from MEM next cycle.
    if (use_rs && exe_wreg && !exe_mem2reg && (exe_rd != REG_X0) && (exe_rd == rs)) begin
      fwd = FWD_EXE;
    end else if (use_rs && mem_wreg && (mem_rd != REG_X0) && (mem_rd == rs)) begin
      fwd = FWD_MEM;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: load-use stall, multicycle sequencing with watchdog,
// redirect squash and operand forwarding. Optional perf counters under HAZARD_PERF_EN.
module pipe_hazard_ctrl
  import core_pkg::*;
#(
  parameter int MC_TIMEOUT = 64,
  parameter int CNT_W      = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [4:0]       i_id_rs1,
  input  logic [4:0]       i_id_rs2,
  input  logic             i_id_use_rs1,
  input  logic             i_id_use_rs2,
  input  logic             i_id_mc,
  input  logic             i_id_redirect,
  input  logic             i_exe_mem2reg,
  input  logic             i_exe_wreg,
  input  logic [4:0]       i_exe_rd,
  input  logic             i_mem_wreg,
  input  logic [4:0]       i_mem_rd,
  input  logic             i_mc_done,
  output logic             o_pc_en,
  output logic             o_ifid_en,
  output logic             o_ifid_flush,
  output logic             o_idexe_bubble,
  output logic             o_mc_start,
  output logic             o_mc_abort,
  output logic [1:0]       o_fwd_a,
  output logic [1:0]       o_fwd_b,
  output state_t           o_state
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt
`endif
);

  localparam logic [7:0] TO_LAST = 8'(MC_TIMEOUT - 1);

  state_t     state;
  logic [7:0] wait_cnt;
  logic       load_use;
  logic       timeout;
  logic [1:0] fwd_a_sel;
  logic [1:0] fwd_b_sel;

  assign load_use = i_exe_mem2reg && i_exe_wreg && (i_exe_rd != REG_X0) &&
                    ((i_id_use_rs1 && (i_id_rs1 == i_exe_rd)) ||
                     (i_id_use_rs2 && (i_id_rs2 == i_exe_rd)));

  // A done pulse in the last allowed cycle wins over the watchdog.
  assign timeout = (state == MC_WAIT) && (wait_cnt == TO_LAST) && !i_mc_done;

  fwd_sel u_fwd_a (
    .rs          (i_id_rs1),
    .use_rs      (i_id_use_rs1),
    .exe_wreg    (i_exe_wreg),
    .exe_mem2reg (i_exe_mem2reg),
    .exe_rd      (i_exe_rd),
    .mem_wreg    (i_mem_wreg),
    .mem_rd      (i_mem_rd),
    .fwd         (fwd_a_sel)
  );

  fwd_sel u_fwd_b (
    .rs          (i_id_rs2),
    .use_rs      (i_id_use_rs2),
    .exe_wreg    (i_exe_wreg),
    .exe_mem2reg (i_exe_mem2reg),
    .exe_rd      (i_exe_rd),
    .mem_wreg    (i_mem_wreg),
    .mem_rd      (i_mem_rd),
    .fwd         (fwd_b_sel)
  );

  // Multicycle handshake: o_mc_start is a one-cycle request issued from RUN; the unit
  // answers with a one-cycle i_mc_done, only honoured in MC_WAIT; o_mc_abort cancels it.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      case (state)
        RUN: begin
          if (!load_use && i_id_mc) begin
            state    <= MC_WAIT;
            wait_cnt <= '0;
          end
        end
        MC_WAIT: begin
          wait_cnt <= wait_cnt + 8'd1;
          if (i_mc_done || timeout) state <= MC_DRAIN;
        end
        MC_DRAIN: state <= RUN;
        default:  state <= RUN;
      endcase
    end
  end

  always_comb begin
    o_pc_en        = 1'b1;
    o_ifid_en      = 1'b1;
    o_ifid_flush   = 1'b0;
    o_idexe_bubble = 1'b0;
    o_mc_start     = 1'b0;
    o_mc_abort     = 1'b0;
    o_fwd_a        = fwd_a_sel;
    o_fwd_b        = fwd_b_sel;
    case (state)
      RUN: begin
        // ID operands are stale under load-use, so mc/redirect wait for the retry.
        if (load_use) begin
          o_pc_en        = 1'b0;
          o_ifid_en      = 1'b0;
          o_idexe_bubble = 1'b1;
        end else if (i_id_mc) begin
          o_pc_en        = 1'b0;
          o_ifid_en      = 1'b0;
          o_idexe_bubble = 1'b1;
          o_mc_start     = 1'b1;
        end else if (i_id_redirect) begin
          o_ifid_flush = 1'b1;
        end
      end
      MC_WAIT: begin
        o_pc_en        = 1'b0;
        o_ifid_en      = 1'b0;
        o_idexe_bubble = 1'b1;
        o_mc_abort     = timeout;
      end
      default: ;
    endcase
    if (i_reset) begin
      o_pc_en        = 1'b0;
      o_ifid_en      = 1'b0;
      o_ifid_flush   = 1'b0;
      o_idexe_bubble = 1'b1;
      o_mc_start     = 1'b0;
      o_mc_abort     = 1'b0;
      o_fwd_a        = FWD_REG;
      o_fwd_b        = FWD_REG;
    end
  end

  assign o_state = state;

`ifdef HAZARD_PERF_EN
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_stall_cnt <= '0;
      o_flush_cnt <= '0;
    end else begin
      if (!o_pc_en && (o_stall_cnt != '1)) o_stall_cnt <= o_stall_cnt + CNT_ONE;
      if (o_ifid_flush && (o_flush_cnt != '1)) o_flush_cnt <= o_flush_cnt + CNT_ONE;
    end
  end
`else
  logic [CNT_W-1:0] unused_cnt_w;
  assign unused_cnt_w = '0;
`endif

endmodule
